// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Purpose : bundles the ID/EX hazard inputs, the start request, the pipeline
//           control outputs and the performance counters of hazard_ctrl.
// Signals : start_i, id_rs_i, id_rt_i, id_branch_i, id_eq_i, id_jump_i,
//           ex_memread_i, ex_rt_i                  (toward the controller)
//           pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
//           running_o, done_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
//                                                  (from the controller)
// Modports: slave  - the controller itself
//           master - the pipeline / environment driving it
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [4:0]       id_rs_i;
  logic [4:0]       id_rt_i;
  logic             id_branch_i;
  logic             id_eq_i;
  logic             id_jump_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rt_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             running_o;
  logic             done_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  start_i, id_rs_i, id_rt_i, id_branch_i, id_eq_i, id_jump_i,
           ex_memread_i, ex_rt_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           running_o, done_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output start_i, id_rs_i, id_rt_i, id_branch_i, id_eq_i, id_jump_i,
           ex_memread_i, ex_rt_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           running_o, done_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Purpose : sequencing controller for the 5-stage pipeline. Owns run/halt,
//           load-use stalls, branch/jump IF/ID flushes and the cycle, stall
//           and flush performance counters.
// Ports   : clk_i   - clock, rising edge
//           rst_i   - synchronous active-high reset
//           hz_bus  - hazard_ctrl_if.slave (hazard inputs, pipeline control
//                     outputs, counters)
// Params  : STALL_CYCLES (1..7) stall cycles per load-use hazard
//           MAX_CYCLES   RUN+STALL cycles before auto-halt, 0 = never
//           CNT_W        counter width (1..32), must match the interface
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int MAX_CYCLES   = 30,
  parameter int CNT_W        = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  hz_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_timer;
  logic [2:0]       w_timer_nxt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_cycle_sat;
  logic [31:0]      w_cycle_ext;

  logic w_hz;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_cyc_inc;
  logic w_stall_inc;
  logic w_flush_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load-use hazard: lw in EX writes a non-zero register read by ID.
  assign w_hz = hz_bus.ex_memread_i &
                (hz_bus.ex_rt_i != 5'd0) &
                ((hz_bus.ex_rt_i == hz_bus.id_rs_i) |
                 (hz_bus.ex_rt_i == hz_bus.id_rt_i));

  // Cycle count after this cycle's increment, used for the auto-halt test.
  assign w_cycle_sat = sat_inc(r_cycle_cnt);
  assign w_cycle_ext = 32'(w_cycle_sat);

  // Next-state, stall timer and pipeline control decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_pc_write    = 1'b0;
    w_ifid_write  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b1;
    w_cyc_inc     = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (hz_bus.start_i) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_cyc_inc = 1'b1;
        if (w_hz) begin
          // Stall wins over any branch/jump sitting in ID; the flush is
          // taken later once the hazard has cleared.
          w_stall_inc = 1'b1;
          if (STALL_CYCLES > 1) begin
            w_state_nxt = S_STALL;
            w_timer_nxt = 3'(STALL_CYCLES - 1);
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_pc_write    = 1'b1;
          w_ifid_write  = 1'b1;
          w_idex_bubble = 1'b0;
          w_ifid_flush  = (hz_bus.id_branch_i & hz_bus.id_eq_i) | hz_bus.id_jump_i;
          w_flush_inc   = w_ifid_flush;
        end
      end
      S_STALL: begin
        // Frozen exactly like a RUN stall cycle; new hazards are not looked at.
        w_cyc_inc   = 1'b1;
        w_stall_inc = 1'b1;
        w_timer_nxt = r_timer - 3'd1;
        if (r_timer == 3'd1) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_STALL;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 3'd0;
      end
    endcase

    // Auto-halt takes priority over whatever RUN/STALL decided.
    if ((MAX_CYCLES != 0) && w_cyc_inc && (w_cycle_ext == 32'(MAX_CYCLES))) begin
      w_state_nxt = S_DONE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, stall timer and performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_timer     <= 3'd0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_cyc_inc) begin
        r_cycle_cnt <= w_cycle_sat;
      end
      if (w_stall_inc) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_flush_inc) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

  assign hz_bus.pc_write_o    = w_pc_write;
  assign hz_bus.ifid_write_o  = w_ifid_write;
  assign hz_bus.ifid_flush_o  = w_ifid_flush;
  assign hz_bus.idex_bubble_o = w_idex_bubble;
  assign hz_bus.running_o     = (r_state == S_RUN) || (r_state == S_STALL);
  assign hz_bus.done_o        = (r_state == S_DONE);
  assign hz_bus.cycle_cnt_o   = r_cycle_cnt;
  assign hz_bus.stall_cnt_o   = r_stall_cnt;
  assign hz_bus.flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Instance A uses single-cycle stalls and
// auto-halt at 30 cycles; instance B uses 3-cycle stalls, no auto-halt and
// 3-bit counters so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   a_cyc;

  hazard_ctrl_if #(.CNT_W(16)) a_if ();
  hazard_ctrl_if #(.CNT_W(3))  b_if ();

  hazard_ctrl #(.STALL_CYCLES(1), .MAX_CYCLES(30), .CNT_W(16)) u_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .hz_bus (a_if)
  );

  hazard_ctrl #(.STALL_CYCLES(3), .MAX_CYCLES(0), .CNT_W(3)) u_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .hz_bus (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a();
    tick();
    a_cyc++;
  endtask

  task automatic clear_a();
    a_if.start_i = 1'b0; a_if.id_rs_i = 5'd0; a_if.id_rt_i = 5'd0;
    a_if.id_branch_i = 1'b0; a_if.id_eq_i = 1'b0; a_if.id_jump_i = 1'b0;
    a_if.ex_memread_i = 1'b0; a_if.ex_rt_i = 5'd0;
    #1;
  endtask

  task automatic clear_b();
    b_if.start_i = 1'b0; b_if.id_rs_i = 5'd0; b_if.id_rt_i = 5'd0;
    b_if.id_branch_i = 1'b0; b_if.id_eq_i = 1'b0; b_if.id_jump_i = 1'b0;
    b_if.ex_memread_i = 1'b0; b_if.ex_rt_i = 5'd0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_a();
    clear_b();
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (a_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL rst_pc_write: got %b want 0", a_if.pc_write_o); end
    n_vec++; if (a_if.ifid_write_o !== 1'b0) begin n_err++; $display("FAIL rst_ifid_write: got %b want 0", a_if.ifid_write_o); end
    n_vec++; if (a_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", a_if.ifid_flush_o); end
    n_vec++; if (a_if.idex_bubble_o !== 1'b1) begin n_err++; $display("FAIL rst_bubble: got %b want 1", a_if.idex_bubble_o); end
    n_vec++; if (a_if.running_o !== 1'b0) begin n_err++; $display("FAIL rst_running: got %b want 0", a_if.running_o); end
    n_vec++; if (a_if.done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", a_if.done_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'd0) begin n_err++; $display("FAIL rst_cycle_cnt: got %0d want 0", a_if.cycle_cnt_o); end
    n_vec++; if (a_if.stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", a_if.stall_cnt_o); end
    n_vec++; if (a_if.flush_cnt_o !== 16'd0) begin n_err++; $display("FAIL rst_flush_cnt: got %0d want 0", a_if.flush_cnt_o); end
    n_vec++; if (b_if.running_o !== 1'b0) begin n_err++; $display("FAIL rst_b_running: got %b want 0", b_if.running_o); end
  endtask

  task automatic test_start();
    // Inputs in IDLE other than start must not wake the pipeline.
    a_if.id_jump_i = 1'b1;
    tick();
    n_vec++; if (a_if.running_o !== 1'b0) begin n_err++; $display("FAIL idle_stays: got %b want 0", a_if.running_o); end
    n_vec++; if (a_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL idle_flush: got %b want 0", a_if.ifid_flush_o); end
    clear_a();
    a_if.start_i = 1'b1;
    #1;
    n_vec++; if (a_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL start_pc_before: got %b want 0", a_if.pc_write_o); end
    tick();
    a_if.start_i = 1'b0;
    #1;
    n_vec++; if (a_if.running_o !== 1'b1) begin n_err++; $display("FAIL start_running: got %b want 1", a_if.running_o); end
    n_vec++; if (a_if.pc_write_o !== 1'b1) begin n_err++; $display("FAIL start_pc_after: got %b want 1", a_if.pc_write_o); end
    n_vec++; if (a_if.idex_bubble_o !== 1'b0) begin n_err++; $display("FAIL start_bubble: got %b want 0", a_if.idex_bubble_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'd0) begin n_err++; $display("FAIL start_cycle_cnt: got %0d want 0", a_if.cycle_cnt_o); end
  endtask

  task automatic test_loaduse();
    // rs match
    a_if.ex_memread_i = 1'b1; a_if.ex_rt_i = 5'd8; a_if.id_rs_i = 5'd8; a_if.id_rt_i = 5'd3;
    #1;
    n_vec++; if (a_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL lu_rs_pc: got %b want 0", a_if.pc_write_o); end
    n_vec++; if (a_if.ifid_write_o !== 1'b0) begin n_err++; $display("FAIL lu_rs_ifid: got %b want 0", a_if.ifid_write_o); end
    n_vec++; if (a_if.idex_bubble_o !== 1'b1) begin n_err++; $display("FAIL lu_rs_bubble: got %b want 1", a_if.idex_bubble_o); end
    tick_a();
    clear_a();
    n_vec++; if (a_if.stall_cnt_o !== 16'd1) begin n_err++; $display("FAIL lu_rs_stall_cnt: got %0d want 1", a_if.stall_cnt_o); end
    n_vec++; if (a_if.pc_write_o !== 1'b1) begin n_err++; $display("FAIL lu_resume_pc: got %b want 1", a_if.pc_write_o); end
    // rt match
    a_if.ex_memread_i = 1'b1; a_if.ex_rt_i = 5'd9; a_if.id_rs_i = 5'd2; a_if.id_rt_i = 5'd9;
    #1;
    n_vec++; if (a_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL lu_rt_pc: got %b want 0", a_if.pc_write_o); end
    tick_a();
    clear_a();
    n_vec++; if (a_if.stall_cnt_o !== 16'd2) begin n_err++; $display("FAIL lu_rt_stall_cnt: got %0d want 2", a_if.stall_cnt_o); end
    // register match but no load in EX
    a_if.ex_memread_i = 1'b0; a_if.ex_rt_i = 5'd8; a_if.id_rs_i = 5'd8;
    #1;
    n_vec++; if (a_if.pc_write_o !== 1'b1) begin n_err++; $display("FAIL nolw_pc: got %b want 1", a_if.pc_write_o); end
    tick_a();
    clear_a();
    n_vec++; if (a_if.stall_cnt_o !== 16'd2) begin n_err++; $display("FAIL nolw_stall_cnt: got %0d want 2", a_if.stall_cnt_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'(a_cyc)) begin n_err++; $display("FAIL lu_cycle_cnt: got %0d want %0d", a_if.cycle_cnt_o, a_cyc); end
  endtask

  task automatic test_zero_reg();
    a_if.ex_memread_i = 1'b1; a_if.ex_rt_i = 5'd0; a_if.id_rs_i = 5'd0; a_if.id_rt_i = 5'd0;
    #1;
    n_vec++; if (a_if.pc_write_o !== 1'b1) begin n_err++; $display("FAIL r0_pc: got %b want 1", a_if.pc_write_o); end
    n_vec++; if (a_if.idex_bubble_o !== 1'b0) begin n_err++; $display("FAIL r0_bubble: got %b want 0", a_if.idex_bubble_o); end
    tick_a();
    clear_a();
    n_vec++; if (a_if.stall_cnt_o !== 16'd2) begin n_err++; $display("FAIL r0_stall_cnt: got %0d want 2", a_if.stall_cnt_o); end
  endtask

  task automatic test_stall_beats_flush();
    a_if.ex_memread_i = 1'b1; a_if.ex_rt_i = 5'd8; a_if.id_rs_i = 5'd8;
    a_if.id_branch_i = 1'b1; a_if.id_eq_i = 1'b1;
    #1;
    n_vec++; if (a_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL sbf_flush: got %b want 0", a_if.ifid_flush_o); end
    n_vec++; if (a_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL sbf_pc: got %b want 0", a_if.pc_write_o); end
    tick_a();
    a_if.ex_memread_i = 1'b0;
    #1;
    n_vec++; if (a_if.flush_cnt_o !== 16'd0) begin n_err++; $display("FAIL sbf_flush_cnt0: got %0d want 0", a_if.flush_cnt_o); end
    n_vec++; if (a_if.stall_cnt_o !== 16'd3) begin n_err++; $display("FAIL sbf_stall_cnt: got %0d want 3", a_if.stall_cnt_o); end
    n_vec++; if (a_if.ifid_flush_o !== 1'b1) begin n_err++; $display("FAIL br_flush: got %b want 1", a_if.ifid_flush_o); end
    n_vec++; if (a_if.pc_write_o !== 1'b1) begin n_err++; $display("FAIL br_pc: got %b want 1", a_if.pc_write_o); end
    tick_a();
    n_vec++; if (a_if.flush_cnt_o !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt: got %0d want 1", a_if.flush_cnt_o); end
    // branch not taken
    a_if.id_eq_i = 1'b0;
    #1;
    n_vec++; if (a_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL brnt_flush: got %b want 0", a_if.ifid_flush_o); end
    tick_a();
    n_vec++; if (a_if.flush_cnt_o !== 16'd1) begin n_err++; $display("FAIL brnt_flush_cnt: got %0d want 1", a_if.flush_cnt_o); end
    // jump
    a_if.id_branch_i = 1'b0; a_if.id_jump_i = 1'b1;
    #1;
    n_vec++; if (a_if.ifid_flush_o !== 1'b1) begin n_err++; $display("FAIL j_flush: got %b want 1", a_if.ifid_flush_o); end
    tick_a();
    clear_a();
    n_vec++; if (a_if.flush_cnt_o !== 16'd2) begin n_err++; $display("FAIL j_flush_cnt: got %0d want 2", a_if.flush_cnt_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'(a_cyc)) begin n_err++; $display("FAIL sbf_cycle_cnt: got %0d want %0d", a_if.cycle_cnt_o, a_cyc); end
  endtask

  task automatic test_max_cycles();
    while (a_cyc < 29) tick_a();
    n_vec++; if (a_if.done_o !== 1'b0) begin n_err++; $display("FAIL max29_done: got %b want 0", a_if.done_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'd29) begin n_err++; $display("FAIL max29_cycle_cnt: got %0d want 29", a_if.cycle_cnt_o); end
    tick_a();
    n_vec++; if (a_if.done_o !== 1'b1) begin n_err++; $display("FAIL max_done: got %b want 1", a_if.done_o); end
    n_vec++; if (a_if.running_o !== 1'b0) begin n_err++; $display("FAIL max_running: got %b want 0", a_if.running_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'd30) begin n_err++; $display("FAIL max_cycle_cnt: got %0d want 30", a_if.cycle_cnt_o); end
    n_vec++; if (a_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL done_pc: got %b want 0", a_if.pc_write_o); end
    n_vec++; if (a_if.idex_bubble_o !== 1'b1) begin n_err++; $display("FAIL done_bubble: got %b want 1", a_if.idex_bubble_o); end
    // DONE ignores start, jump and hazards
    a_if.start_i = 1'b1; a_if.id_jump_i = 1'b1;
    a_if.ex_memread_i = 1'b1; a_if.ex_rt_i = 5'd4; a_if.id_rs_i = 5'd4;
    #1;
    n_vec++; if (a_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL done_flush: got %b want 0", a_if.ifid_flush_o); end
    tick();
    clear_a();
    n_vec++; if (a_if.done_o !== 1'b1) begin n_err++; $display("FAIL done_sticky: got %b want 1", a_if.done_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'd30) begin n_err++; $display("FAIL done_cycle_hold: got %0d want 30", a_if.cycle_cnt_o); end
    n_vec++; if (a_if.stall_cnt_o !== 16'd3) begin n_err++; $display("FAIL done_stall_hold: got %0d want 3", a_if.stall_cnt_o); end
    n_vec++; if (a_if.flush_cnt_o !== 16'd2) begin n_err++; $display("FAIL done_flush_hold: got %0d want 2", a_if.flush_cnt_o); end
    // reset out of DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (a_if.done_o !== 1'b0) begin n_err++; $display("FAIL rstdone_done: got %b want 0", a_if.done_o); end
    n_vec++; if (a_if.running_o !== 1'b0) begin n_err++; $display("FAIL rstdone_running: got %b want 0", a_if.running_o); end
    n_vec++; if (a_if.cycle_cnt_o !== 16'd0) begin n_err++; $display("FAIL rstdone_cycle_cnt: got %0d want 0", a_if.cycle_cnt_o); end
    n_vec++; if (a_if.stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL rstdone_stall_cnt: got %0d want 0", a_if.stall_cnt_o); end
    n_vec++; if (a_if.flush_cnt_o !== 16'd0) begin n_err++; $display("FAIL rstdone_flush_cnt: got %0d want 0", a_if.flush_cnt_o); end
  endtask

  task automatic test_multi_stall();
    b_if.start_i = 1'b1;
    tick();
    b_if.start_i = 1'b0;
    #1;
    n_vec++; if (b_if.running_o !== 1'b1) begin n_err++; $display("FAIL b_start_running: got %b want 1", b_if.running_o); end
    b_if.ex_memread_i = 1'b1; b_if.ex_rt_i = 5'd5; b_if.id_rs_i = 5'd5;
    #1;
    n_vec++; if (b_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL ms1_pc: got %b want 0", b_if.pc_write_o); end
    tick();
    clear_b();
    b_if.id_jump_i = 1'b1;
    #1;
    n_vec++; if (b_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL ms2_pc: got %b want 0", b_if.pc_write_o); end
    n_vec++; if (b_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL ms2_flush: got %b want 0", b_if.ifid_flush_o); end
    n_vec++; if (b_if.running_o !== 1'b1) begin n_err++; $display("FAIL ms2_running: got %b want 1", b_if.running_o); end
    n_vec++; if (b_if.stall_cnt_o !== 3'd1) begin n_err++; $display("FAIL ms2_stall_cnt: got %0d want 1", b_if.stall_cnt_o); end
    tick();
    n_vec++; if (b_if.pc_write_o !== 1'b0) begin n_err++; $display("FAIL ms3_pc: got %b want 0", b_if.pc_write_o); end
    n_vec++; if (b_if.ifid_flush_o !== 1'b0) begin n_err++; $display("FAIL ms3_flush: got %b want 0", b_if.ifid_flush_o); end
    n_vec++; if (b_if.stall_cnt_o !== 3'd2) begin n_err++; $display("FAIL ms3_stall_cnt: got %0d want 2", b_if.stall_cnt_o); end
    tick();
    n_vec++; if (b_if.pc_write_o !== 1'b1) begin n_err++; $display("FAIL ms_back_pc: got %b want 1", b_if.pc_write_o); end
    n_vec++; if (b_if.ifid_flush_o !== 1'b1) begin n_err++; $display("FAIL ms_back_flush: got %b want 1", b_if.ifid_flush_o); end
    n_vec++; if (b_if.stall_cnt_o !== 3'd3) begin n_err++; $display("FAIL ms_stall_cnt: got %0d want 3", b_if.stall_cnt_o); end
    n_vec++; if (b_if.flush_cnt_o !== 3'd0) begin n_err++; $display("FAIL ms_flush_cnt: got %0d want 0", b_if.flush_cnt_o); end
    n_vec++; if (b_if.cycle_cnt_o !== 3'd3) begin n_err++; $display("FAIL ms_cycle_cnt: got %0d want 3", b_if.cycle_cnt_o); end
  endtask

  task automatic test_saturation();
    // eight back-to-back jumps: flush_cnt and cycle_cnt both pin at 7
    for (int i = 0; i < 8; i++) tick();
    clear_b();
    n_vec++; if (b_if.flush_cnt_o !== 3'd7) begin n_err++; $display("FAIL sat_flush_cnt: got %0d want 7", b_if.flush_cnt_o); end
    n_vec++; if (b_if.cycle_cnt_o !== 3'd7) begin n_err++; $display("FAIL sat_cycle_cnt: got %0d want 7", b_if.cycle_cnt_o); end
    n_vec++; if (b_if.running_o !== 1'b1) begin n_err++; $display("FAIL nohalt_running: got %b want 1", b_if.running_o); end
    n_vec++; if (b_if.done_o !== 1'b0) begin n_err++; $display("FAIL nohalt_done: got %b want 0", b_if.done_o); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    a_cyc = 0;
    rst   = 1'b1;
    test_reset();
    test_start();
    test_loaduse();
    test_zero_reg();
    test_stall_beats_flush();
    test_max_cycles();
    test_multi_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
